// File: rtl/beat_recorder.sv
// beat_recorder: records live key codes as (note, dur) events and replays them.
// Build option: define BEAT_RECORDER_LOOP_EN to repeat playback until stop/reset.
// Ports: clk; reset (sync, active-high); ascii_in (live key, 0 = none);
//   record/play/stop (1-cycle pulses); ascii_out (to rate_divider);
//   state (IDLE=0 REC=1 LOAD=2 PLAY=3); count (stored entries); full.
module beat_recorder #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             ascii_in,
  input  logic                   record,
  input  logic                   play,
  input  logic                   stop,
  output logic [6:0]             ascii_out,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int EW = 7 + DUR_W;
  localparam logic [DUR_W-1:0] DMAX  = '1;
  localparam logic [DUR_W-1:0] DONE  = DUR_W'(1);
  localparam logic [TW-1:0]    TLAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]    CFULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_LOAD = 2'd2,
    S_PLAY = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic [6:0]       r_out, w_out;
  logic [CW-1:0]    r_count, w_count;
  logic             r_full, w_full;
  logic [AW-1:0]    r_addr, w_addr;
  logic [DUR_W-1:0] r_dur, w_dur;
  logic [DUR_W-1:0] r_remain, w_remain;
  logic [6:0]       r_note, w_note;
  logic [TW-1:0]    r_tcnt, w_tcnt;
  logic             r_ph, w_ph;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [EW-1:0]    r_rdata;
  logic             w_we;
  logic [EW-1:0]    w_wdata;
  logic             w_tick;
  logic             w_sat;
  logic             w_chg;
  logic             w_last;
  logic [DUR_W-1:0] w_pend;
  logic [CW-1:0]    w_cnt_inc;

  assign w_tick = (r_tcnt == TLAST);
  assign w_sat  = w_tick && (r_dur == DMAX);
  // duration this cycle would close with, tick included
  assign w_pend = (w_tick && !w_sat) ? r_dur + DONE : r_dur;
  assign w_chg  = (ascii_in != r_note);
  assign w_cnt_inc = r_count + CW'(1);
  assign w_last = ({1'b0, r_addr} + CW'(1)) == r_count;
  assign w_wdata = {r_note, w_pend};

  always_comb begin
    w_state  = r_state;
    w_out    = r_out;
    w_count  = r_count;
    w_full   = r_full;
    w_addr   = r_addr;
    w_dur    = r_dur;
    w_remain = r_remain;
    w_note   = r_note;
    w_ph     = r_ph;
    w_we     = 1'b0;
    w_tcnt   = w_tick ? '0 : r_tcnt + TW'(1);
    unique case (r_state)
      S_IDLE: begin
        w_out = ascii_in;
        if (!stop && record) begin
          w_state = S_REC;
          w_count = '0;
          w_full  = 1'b0;
          w_note  = ascii_in;
          w_dur   = '0;
          w_tcnt  = '0;
        end else if (!stop && play && r_count != '0) begin
          w_state = S_LOAD;
          w_addr  = '0;
          w_ph    = 1'b0;
          w_tcnt  = '0;
        end
      end
      S_REC: begin
        w_out = ascii_in;
        if (stop) begin
          w_state = S_IDLE;
          w_we    = (w_pend != '0);
        end else if (w_chg) begin
          // zero-length note is a glitch: swap note, store nothing
          w_we   = (w_pend != '0);
          w_note = ascii_in;
          w_dur  = '0;
          w_tcnt = '0;
        end else if (w_sat) begin
          w_we  = 1'b1;
          w_dur = '0;
        end else begin
          w_dur = w_pend;
        end
        if (w_we) begin
          w_count = w_cnt_inc;
          if (w_cnt_inc == CFULL) begin
            w_full  = 1'b1;
            w_state = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        // tick counter held so each note starts a fresh tick period
        w_tcnt = '0;
        if (stop) begin
          w_state = S_IDLE;
        end else if (!r_ph) begin
          w_ph = 1'b1;
        end else begin
          w_out    = r_rdata[EW-1 -: 7];
          w_remain = r_rdata[DUR_W-1:0];
          w_state  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (stop) begin
          w_state = S_IDLE;
        end else if (w_tick) begin
          if (r_remain <= DONE) begin
            w_remain = '0;
            if (!w_last) begin
              w_addr  = r_addr + AW'(1);
              w_state = S_LOAD;
              w_ph    = 1'b0;
              w_tcnt  = '0;
            end else begin
`ifdef BEAT_RECORDER_LOOP_EN
              w_addr  = '0;
              w_state = S_LOAD;
              w_ph    = 1'b0;
              w_tcnt  = '0;
`else
              w_state = S_IDLE;
`endif
            end
          end else begin
            w_remain = r_remain - DONE;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out    <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_addr   <= '0;
      r_dur    <= '0;
      r_remain <= '0;
      r_note   <= '0;
      r_tcnt   <= '0;
      r_ph     <= 1'b0;
    end else begin
      r_out    <= w_out;
      r_count  <= w_count;
      r_full   <= w_full;
      r_addr   <= w_addr;
      r_dur    <= w_dur;
      r_remain <= w_remain;
      r_note   <= w_note;
      r_tcnt   <= w_tcnt;
      r_ph     <= w_ph;
    end
  end

  // storage is deliberately not reset so a recording survives reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_count[AW-1:0]] <= w_wdata;
    r_rdata <= r_mem[r_addr];
  end

  assign ascii_out = r_out;
  assign state     = r_state;
  assign count     = r_count;
  assign full      = r_full;

endmodule

// File: tb/tb_beat_recorder.sv
// tb_beat_recorder: directed checks of beat_recorder with
// DEPTH=4, TICK_DIV=4, DUR_W=4.
module tb_beat_recorder;
  logic       clk;
  logic       reset;
  logic [6:0] ascii_in;
  logic       record;
  logic       play;
  logic       stop;
  logic [6:0] ascii_out;
  logic [1:0] state;
  logic [2:0] count;
  logic       full;

  int n_run;
  int n_fail;

  beat_recorder #(
    .DEPTH(4),
    .TICK_DIV(4),
    .DUR_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ascii_in(ascii_in),
    .record(record),
    .play(play),
    .stop(stop),
    .ascii_out(ascii_out),
    .state(state),
    .count(count),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
    n_run++; if (ascii_out !== 7'd0) begin n_fail++; $display("FAIL rst_out got %0d exp 0", ascii_out); end
    n_run++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_run++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0d exp 0", full); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_record();
    ascii_in = 7'd65;
    record = 1'b1;
    step(1);
    record = 1'b0;
    n_run++; if (state !== 2'd1) begin n_fail++; $display("FAIL rec_state got %0d exp 1", state); end
    step(11);
    ascii_in = 7'd87;
    step(8);
    n_run++; if (count !== 3'd1) begin n_fail++; $display("FAIL rec_mid_count got %0d exp 1", count); end
    n_run++; if (dut.r_mem[0] !== {7'd65, 4'd3}) begin n_fail++; $display("FAIL rec_e0 got %h exp %h", dut.r_mem[0], {7'd65, 4'd3}); end
    n_run++; if (ascii_out !== 7'd87) begin n_fail++; $display("FAIL rec_pass got %0d exp 87", ascii_out); end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL rec_stop_state got %0d exp 0", state); end
    n_run++; if (count !== 3'd2) begin n_fail++; $display("FAIL rec_count got %0d exp 2", count); end
    n_run++; if (dut.r_mem[1] !== {7'd87, 4'd2}) begin n_fail++; $display("FAIL rec_e1 got %h exp %h", dut.r_mem[1], {7'd87, 4'd2}); end
    ascii_in = 7'd0;
    step(2);
  endtask

  task automatic test_play();
    play = 1'b1;
    step(1);
    play = 1'b0;
    ascii_in = 7'd33;
    n_run++; if (state !== 2'd2) begin n_fail++; $display("FAIL play_load got %0d exp 2", state); end
    step(1);
    n_run++; if (ascii_out !== 7'd0) begin n_fail++; $display("FAIL play_hold got %0d exp 0", ascii_out); end
    step(1);
    n_run++; if (ascii_out !== 7'd65) begin n_fail++; $display("FAIL play_n0_start got %0d exp 65", ascii_out); end
    n_run++; if (state !== 2'd3) begin n_fail++; $display("FAIL play_state got %0d exp 3", state); end
    step(11);
    n_run++; if (ascii_out !== 7'd65) begin n_fail++; $display("FAIL play_n0_end got %0d exp 65", ascii_out); end
    n_run++; if (state !== 2'd3) begin n_fail++; $display("FAIL play_n0_st got %0d exp 3", state); end
    step(1);
    n_run++; if (state !== 2'd2) begin n_fail++; $display("FAIL play_load2 got %0d exp 2", state); end
    step(2);
    n_run++; if (ascii_out !== 7'd87) begin n_fail++; $display("FAIL play_n1_start got %0d exp 87", ascii_out); end
    step(7);
    n_run++; if (ascii_out !== 7'd87) begin n_fail++; $display("FAIL play_n1_end got %0d exp 87", ascii_out); end
    step(1);
`ifdef BEAT_RECORDER_LOOP_EN
    n_run++; if (state !== 2'd2) begin n_fail++; $display("FAIL loop_load got %0d exp 2", state); end
    step(2);
    n_run++; if (ascii_out !== 7'd65) begin n_fail++; $display("FAIL loop_n0 got %0d exp 65", ascii_out); end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL loop_stop got %0d exp 0", state); end
    step(1);
`else
    n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL play_idle got %0d exp 0", state); end
    step(1);
`endif
    n_run++; if (ascii_out !== 7'd33) begin n_fail++; $display("FAIL play_pass got %0d exp 33", ascii_out); end
    ascii_in = 7'd0;
    step(1);
  endtask

  task automatic test_cmd();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    play = 1'b1;
    step(1);
    play = 1'b0;
    n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL cmd_play_empty got %0d exp 0", state); end
    ascii_in = 7'd50;
    record = 1'b1;
    play = 1'b1;
    step(1);
    record = 1'b0;
    n_run++; if (state !== 2'd1) begin n_fail++; $display("FAIL cmd_rec_prio got %0d exp 1", state); end
    step(1);
    play = 1'b0;
    n_run++; if (state !== 2'd1) begin n_fail++; $display("FAIL cmd_play_in_rec got %0d exp 1", state); end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL cmd_stop got %0d exp 0", state); end
    n_run++; if (count !== 3'd0) begin n_fail++; $display("FAIL cmd_count got %0d exp 0", count); end
    ascii_in = 7'd0;
    step(1);
  endtask

  task automatic test_glitch();
    ascii_in = 7'd65;
    record = 1'b1;
    step(1);
    record = 1'b0;
    ascii_in = 7'd69;
    step(1);
    ascii_in = 7'd65;
    step(8);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_run++; if (count !== 3'd1) begin n_fail++; $display("FAIL glitch_count got %0d exp 1", count); end
    n_run++; if (dut.r_mem[0] !== {7'd65, 4'd2}) begin n_fail++; $display("FAIL glitch_e0 got %h exp %h", dut.r_mem[0], {7'd65, 4'd2}); end
    ascii_in = 7'd0;
    step(1);
  endtask

  task automatic test_saturation();
    ascii_in = 7'd65;
    record = 1'b1;
    step(1);
    record = 1'b0;
    step(64);
    n_run++; if (count !== 3'd1) begin n_fail++; $display("FAIL sat_mid_count got %0d exp 1", count); end
    n_run++; if (dut.r_mem[0] !== {7'd65, 4'd15}) begin n_fail++; $display("FAIL sat_e0 got %h exp %h", dut.r_mem[0], {7'd65, 4'd15}); end
    step(8);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_run++; if (count !== 3'd2) begin n_fail++; $display("FAIL sat_count got %0d exp 2", count); end
    n_run++; if (dut.r_mem[1] !== {7'd65, 4'd2}) begin n_fail++; $display("FAIL sat_e1 got %h exp %h", dut.r_mem[1], {7'd65, 4'd2}); end
    ascii_in = 7'd0;
    step(1);
  endtask

  task automatic test_sat_change();
    ascii_in = 7'd65;
    record = 1'b1;
    step(1);
    record = 1'b0;
    step(63);
    ascii_in = 7'd70;
    step(1);
    n_run++; if (count !== 3'd1) begin n_fail++; $display("FAIL satchg_count got %0d exp 1", count); end
    n_run++; if (dut.r_mem[0] !== {7'd65, 4'd15}) begin n_fail++; $display("FAIL satchg_e0 got %h exp %h", dut.r_mem[0], {7'd65, 4'd15}); end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_run++; if (count !== 3'd1) begin n_fail++; $display("FAIL satchg_stop got %0d exp 1", count); end
    ascii_in = 7'd0;
    step(1);
  endtask

  task automatic test_full(input bit with_stop);
    ascii_in = 7'd10;
    record = 1'b1;
    step(1);
    record = 1'b0;
    step(7);
    ascii_in = 7'd20;
    step(8);
    ascii_in = 7'd30;
    step(8);
    ascii_in = 7'd40;
    step(8);
    if (with_stop) stop = 1'b1;
    else ascii_in = 7'd50;
    step(1);
    stop = 1'b0;
    n_run++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count[%0d] got %0d exp 4", with_stop, count); end
    n_run++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag[%0d] got %0d exp 1", with_stop, full); end
    n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL full_state[%0d] got %0d exp 0", with_stop, state); end
    n_run++; if (dut.r_mem[0] !== {7'd10, 4'd2}) begin n_fail++; $display("FAIL full_e0[%0d] got %h exp %h", with_stop, dut.r_mem[0], {7'd10, 4'd2}); end
    n_run++; if (dut.r_mem[3] !== {7'd40, 4'd2}) begin n_fail++; $display("FAIL full_e3[%0d] got %h exp %h", with_stop, dut.r_mem[3], {7'd40, 4'd2}); end
    ascii_in = 7'd60;
    step(15);
    n_run++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_after[%0d] got %0d exp 4", with_stop, count); end
    n_run++; if (ascii_out !== 7'd60) begin n_fail++; $display("FAIL full_pass[%0d] got %0d exp 60", with_stop, ascii_out); end
    ascii_in = 7'd0;
    step(1);
  endtask

  task automatic test_reset_play();
    play = 1'b1;
    step(1);
    play = 1'b0;
    step(2);
    n_run++; if (ascii_out !== 7'd10) begin n_fail++; $display("FAIL rp_note got %0d exp 10", ascii_out); end
    n_run++; if (state !== 2'd3) begin n_fail++; $display("FAIL rp_play got %0d exp 3", state); end
    reset = 1'b1;
    step(1);
    n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL rp_state got %0d exp 0", state); end
    n_run++; if (ascii_out !== 7'd0) begin n_fail++; $display("FAIL rp_out got %0d exp 0", ascii_out); end
    n_run++; if (count !== 3'd0) begin n_fail++; $display("FAIL rp_count got %0d exp 0", count); end
    n_run++; if (full !== 1'b0) begin n_fail++; $display("FAIL rp_full got %0d exp 0", full); end
    n_run++; if (dut.r_mem[0] !== {7'd10, 4'd2}) begin n_fail++; $display("FAIL rp_mem got %h exp %h", dut.r_mem[0], {7'd10, 4'd2}); end
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    reset = 1'b1;
    ascii_in = 7'd0;
    record = 1'b0;
    play = 1'b0;
    stop = 1'b0;
    step(1);
    test_reset();
    test_record();
    test_play();
    test_cmd();
    test_glitch();
    test_saturation();
    test_sat_change();
    test_full(1'b0);
    test_full(1'b1);
    test_reset_play();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
